// File: rtl/accum_control_unit_if.sv
// Bus bundle between the accumulator controller and its neighbours: instruction ROM
// port, ALU decode/overflow lines, write enables and the data memory handshake.
interface accum_control_unit_if #(
    parameter int PC_W = 10
) ();
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_rdata;
    logic [3:0]      OP;
    logic            type_bit;
    logic [3:0]      reg_sel;
    logic            acc_zero;
    logic            alu_overflow;
    logic            overflow_q;
    logic            acc_we;
    logic            reg_we;
    logic            dmem_re;
    logic            dmem_we;
    logic            dmem_ready;

    // Controller side
    modport master (
        output imem_addr, OP, type_bit, reg_sel, overflow_q,
               acc_we, reg_we, dmem_re, dmem_we,
        input  imem_rdata, acc_zero, alu_overflow, dmem_ready
    );

    // ROM / ALU / data memory side
    modport slave (
        input  imem_addr, OP, type_bit, reg_sel, overflow_q,
               acc_we, reg_we, dmem_re, dmem_we,
        output imem_rdata, acc_zero, alu_overflow, dmem_ready
    );
endinterface

// File: rtl/accum_control_unit.sv
// Fetch/decode/sequence controller for the 8-bit accumulator datapath.
// Owns PC, IR, the architectural overflow flag and the retired-instruction counter.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | after reset, waiting for start
//   S_FETCH  | ROM address = PC, ROM data returns next cycle
//   S_DECODE | IR captured from ROM at end of cycle
//   S_EXEC   | one-cycle enables, branch / PC update, or hand off to MEM
//   S_MEM    | load/store request held until dmem_ready
//   S_HALTED | halt retired, waiting for start
module accum_control_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    accum_control_unit_if.master bus,
    output logic                 halted,
    output logic                 busy,
    output logic [CNT_W-1:0]     instr_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED
    } state_t;

    localparam logic [3:0] OP_PUT   = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd11;
    localparam logic [3:0] OP_OF0   = 4'd13;
    localparam logic [3:0] OP_HALT  = 4'd14;
    localparam logic [3:0] OP_TBA   = 4'd15;

    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t          state, state_d;
    logic [PC_W-1:0] pc, pc_d;
    logic [8:0]      ir, ir_d;
    logic            ovf, ovf_d;
    logic            retire, cnt_clr;
    logic            acc_we, reg_we, dmem_re, dmem_we;
    logic            is_load;
    logic [PC_W-1:0] br_offset;

    // Only load/store ever reach MEM, so the opcode alone picks the direction.
    assign is_load   = (ir[7:4] == OP_LOAD);
    assign br_offset = PC_W'($signed(ir[7:0]));

    assign bus.imem_addr  = pc;
    assign bus.OP         = ir[7:4];
    assign bus.type_bit   = ir[8];
    assign bus.reg_sel    = ir[3:0];
    assign bus.overflow_q = ovf;
    assign bus.acc_we     = acc_we;
    assign bus.reg_we     = reg_we;
    assign bus.dmem_re    = dmem_re;
    assign bus.dmem_we    = dmem_we;

    assign halted = (state == S_HALTED);
    assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                    (state == S_EXEC)  || (state == S_MEM);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_d;
    end

    // Architectural registers and saturating retire counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc          <= '0;
            ir          <= '0;
            ovf         <= 1'b0;
            instr_count <= '0;
        end else begin
            pc  <= pc_d;
            ir  <= ir_d;
            ovf <= ovf_d;
            if (cnt_clr)
                instr_count <= '0;
            else if (retire && (instr_count != '1))
                instr_count <= instr_count + CNT_ONE;
        end
    end

    // Next-state, register updates and single-cycle enables
    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;
        ovf_d   = ovf;
        retire  = 1'b0;
        cnt_clr = 1'b0;
        acc_we  = 1'b0;
        reg_we  = 1'b0;
        dmem_re = 1'b0;
        dmem_we = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    ovf_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = bus.imem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc + PC_ONE;
                retire  = 1'b1;
                if (ir[8]) begin
                    if (!bus.acc_zero) pc_d = pc + br_offset;
                end else begin
                    case (ir[7:4])
                        OP_PUT: reg_we = 1'b1;
                        OP_LOAD, OP_STORE: begin
                            state_d = S_MEM;
                            pc_d    = pc;
                            retire  = 1'b0;
                        end
                        OP_ADD: begin
                            acc_we = 1'b1;
                            ovf_d  = bus.alu_overflow;
                        end
                        OP_OF0:  ovf_d = 1'b0;
                        OP_HALT: begin
                            state_d = S_HALTED;
                            pc_d    = pc;
                        end
                        OP_TBA: begin
                        end
                        default: acc_we = 1'b1;
                    endcase
                end
            end
            S_MEM: begin
                dmem_re = is_load;
                dmem_we = !is_load;
                if (bus.dmem_ready) begin
                    acc_we  = is_load;
                    pc_d    = pc + PC_ONE;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_accum_control_unit.sv
// Self-checking bench for accum_control_unit: instruction-level reference model,
// randomized ALU/memory inputs and directed scenarios from the usage notes.
module tb_accum_control_unit;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic        halted;
    logic        busy;
    logic [15:0] instr_count;

    accum_control_unit_if #(.PC_W(10)) bus ();

    accum_control_unit #(.PC_W(10), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .bus(bus.master),
        .halted(halted), .busy(busy), .instr_count(instr_count)
    );

    always #5 CLK = ~CLK;

    logic [8:0] rom [0:1023];
    always @(posedge CLK) bus.imem_rdata <= rom[bus.imem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: architectural state at instruction granularity
    logic [9:0] m_pc;
    logic       m_ov;
    int         m_cnt;

    int az_mode;   // 0 random, 1 force 0, 2 force 1
    int ao_mode;
    int mem_lat;   // 0 random 1..4
    bit noise;     // random start / dmem_ready while busy
    int last_cycles;
    int last_re;

    task automatic noise_drive();
        if (noise) start = 1'($urandom_range(0, 1));
        bus.dmem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        RESET = 1'b1; start = 1'b0; bus.dmem_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        m_pc = '0; m_ov = 1'b0; m_cnt = 0;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Called at the negedge of a FETCH cycle; runs one instruction against the model.
    task automatic run_instr(output bit hit_halt);
        logic [8:0] ins;
        logic [3:0] op;
        bit az, ao, e_acc, e_reg, is_mem, is_ld;
        int lat;
        hit_halt = 1'b0;
        n_checks++; if (bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL fetch_addr: got %0d expected %0d", bus.imem_addr, m_pc); end
        n_checks++; if ({busy, halted} !== 2'b10) begin n_fail++; $display("FAIL fetch_busy: got busy=%b halted=%b expected 1/0", busy, halted); end
        n_checks++; if (bus.overflow_q !== m_ov) begin n_fail++; $display("FAIL overflow_q @pc%0d: got %b expected %b", m_pc, bus.overflow_q, m_ov); end
        n_checks++; if (instr_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL instr_count: got %0d expected %0d", instr_count, m_cnt); end
        n_checks++; if ({bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we} !== 4'b0) begin n_fail++; $display("FAIL fetch_enables: got %b expected 0000", {bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we}); end
        ins = rom[m_pc];
        op  = ins[7:4];
        noise_drive();
        @(negedge CLK);
        n_checks++; if ({bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we} !== 4'b0) begin n_fail++; $display("FAIL decode_enables: got %b expected 0000", {bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we}); end
        noise_drive();
        @(negedge CLK);
        az = (az_mode == 0) ? 1'($urandom_range(0, 1)) : (az_mode == 2);
        ao = (ao_mode == 0) ? 1'($urandom_range(0, 1)) : (ao_mode == 2);
        bus.acc_zero = az; bus.alu_overflow = ao;
        noise_drive();
        #1;
        n_checks++; if ({bus.type_bit, bus.OP, bus.reg_sel} !== ins) begin n_fail++; $display("FAIL decode_fields: got %b expected %b", {bus.type_bit, bus.OP, bus.reg_sel}, ins); end
        e_acc = 1'b0; e_reg = 1'b0; is_mem = 1'b0;
        if (!ins[8]) begin
            case (op)
                4'd2, 4'd3:   is_mem = 1'b1;
                4'd14:        hit_halt = 1'b1;
                4'd1:         e_reg = 1'b1;
                4'd13, 4'd15: e_acc = 1'b0;
                default:      e_acc = 1'b1;
            endcase
        end
        n_checks++; if ({bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we} !== {e_acc, e_reg, 2'b00}) begin n_fail++; $display("FAIL exec_enables ins=%b: got %b expected %b", ins, {bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we}, {e_acc, e_reg, 2'b00}); end
        if (ins[8]) begin
            if (az) m_pc = 10'(m_pc + 10'd1);
            else    m_pc = 10'(int'(m_pc) + int'($signed(ins[7:0])));
        end else begin
            if (op == 4'd11) m_ov = ao;
            if (op == 4'd13) m_ov = 1'b0;
            if (!is_mem && !hit_halt) m_pc = 10'(m_pc + 10'd1);
        end
        if (!is_mem && m_cnt < 65535) m_cnt++;
        last_cycles = 3;
        last_re = 0;
        if (is_mem) begin
            is_ld = (op == 4'd2);
            lat = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4));
            for (int k = 1; k <= lat; k++) begin
                @(negedge CLK);
                bus.dmem_ready = (k == lat);
                if (noise) start = 1'($urandom_range(0, 1));
                #1;
                last_cycles++;
                if (bus.dmem_re === 1'b1) last_re++;
                n_checks++; if ({bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we, busy} !== {is_ld && (k == lat), 1'b0, is_ld, !is_ld, 1'b1}) begin n_fail++; $display("FAIL mem_phase k=%0d/%0d: got %b expected %b", k, lat, {bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we, busy}, {is_ld && (k == lat), 1'b0, is_ld, !is_ld, 1'b1}); end
            end
            m_pc = 10'(m_pc + 10'd1);
            if (m_cnt < 65535) m_cnt++;
        end
        @(negedge CLK);
        start = 1'b0;
        bus.dmem_ready = 1'b0;
        if (hit_halt) begin
            n_checks++; if ({halted, busy} !== 2'b10) begin n_fail++; $display("FAIL halt_state: got halted=%b busy=%b expected 1/0", halted, busy); end
            n_checks++; if (bus.imem_addr !== m_pc || instr_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL halt_arch: got pc=%0d cnt=%0d expected pc=%0d cnt=%0d", bus.imem_addr, instr_count, m_pc, m_cnt); end
        end
    endtask

    task automatic run_prog(input int max_instr, output bit got_halt);
        bit h;
        got_halt = 1'b0;
        start_pulse();
        for (int i = 0; i < max_instr; i++) begin
            run_instr(h);
            if (h) begin got_halt = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++; if ({halted, busy, bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we, bus.overflow_q} !== 7'b0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 0000000", {halted, busy, bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we, bus.overflow_q}); end
        end
        n_checks++; if ({instr_count, bus.imem_addr, bus.type_bit, bus.OP, bus.reg_sel} !== 35'b0) begin n_fail++; $display("FAIL reset_regs: got cnt=%0d pc=%0d ir=%b expected zeros", instr_count, bus.imem_addr, {bus.type_bit, bus.OP, bus.reg_sel}); end
        RESET = 1'b0; start = 1'b0;
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_without_start: got busy=%b expected 0", busy); end
    endtask

    task automatic test_program();
        int pulses[$];
        int first_halt;
        for (int i = 0; i < 1024; i++) rom[i] = 9'h0F0;
        rom[0] = 9'b0_0000_0001; rom[1] = 9'b0_0100_0010; rom[2] = 9'b0_1110_0000;
        do_reset();
        first_halt = -1;
        start = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge CLK);
            start = 1'b0;
            if (bus.acc_we === 1'b1) pulses.push_back(cyc);
            if (halted === 1'b1 && first_halt < 0) first_halt = cyc;
        end
        n_checks++; if (pulses.size() != 2 || pulses[0] != 3 || pulses[1] != 6) begin n_fail++; $display("FAIL prog_acc_pulses: got %0d pulses first=%0d expected cycles 3 and 6", pulses.size(), (pulses.size() > 0) ? pulses[0] : -1); end
        n_checks++; if (first_halt != 10) begin n_fail++; $display("FAIL prog_halt_cycle: got %0d expected 10", first_halt); end
        n_checks++; if (bus.imem_addr !== 10'd2 || instr_count !== 16'd3) begin n_fail++; $display("FAIL prog_final: got pc=%0d cnt=%0d expected pc=2 cnt=3", bus.imem_addr, instr_count); end
    endtask

    task automatic test_restart();
        bit h;
        rom[0] = 9'b0_1011_0000; rom[1] = 9'b0_1110_0000;
        ao_mode = 2; az_mode = 0; mem_lat = 0; noise = 1'b0;
        run_prog(4, h);
        n_checks++; if (bus.overflow_q !== 1'b1) begin n_fail++; $display("FAIL restart_pre_ovf: got %b expected 1", bus.overflow_q); end
        start_pulse();
        n_checks++; if ({bus.imem_addr, bus.overflow_q, instr_count} !== 27'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_clear: got pc=%0d ovf=%b cnt=%0d busy=%b expected 0/0/0/1", bus.imem_addr, bus.overflow_q, instr_count, busy); end
        run_instr(h);
        run_instr(h);
        n_checks++; if (h !== 1'b1) begin n_fail++; $display("FAIL restart_halt: got %b expected 1", h); end
    endtask

    task automatic test_overflow();
        bit h;
        rom[0] = 9'b0_1011_0001; rom[1] = 9'b0_1100_0010; rom[2] = 9'b0_1101_0000; rom[3] = 9'b0_1110_0000;
        ao_mode = 2;
        start_pulse();
        run_instr(h);
        n_checks++; if (bus.overflow_q !== 1'b1) begin n_fail++; $display("FAIL ovf_after_add: got %b expected 1", bus.overflow_q); end
        ao_mode = 1;
        run_instr(h);
        n_checks++; if (bus.overflow_q !== 1'b1) begin n_fail++; $display("FAIL ovf_after_sub: got %b expected 1", bus.overflow_q); end
        run_instr(h);
        n_checks++; if (bus.overflow_q !== 1'b0) begin n_fail++; $display("FAIL ovf_after_of0: got %b expected 0", bus.overflow_q); end
        run_instr(h);
        ao_mode = 0;
    endtask

    task automatic test_load();
        bit h;
        rom[0] = 9'b0_0010_0011; rom[1] = 9'b0_1110_0000;
        mem_lat = 4;
        start_pulse();
        run_instr(h);
        n_checks++; if (last_re != 4 || last_cycles != 7) begin n_fail++; $display("FAIL load_span: got re=%0d cycles=%0d expected re=4 cycles=7", last_re, last_cycles); end
        run_instr(h);
        mem_lat = 0;
    endtask

    task automatic test_branch();
        bit h;
        for (int i = 0; i < 5; i++) rom[i] = 9'b0_1111_0000;
        rom[5] = 9'b1_1111_1110; rom[6] = 9'b0_1110_0000;
        az_mode = 1;
        start_pulse();
        for (int i = 0; i < 6; i++) run_instr(h);
        n_checks++; if (bus.imem_addr !== 10'd3) begin n_fail++; $display("FAIL branch_taken: got %0d expected 3", bus.imem_addr); end
        do_reset();
        az_mode = 2;
        start_pulse();
        for (int i = 0; i < 6; i++) run_instr(h);
        n_checks++; if (bus.imem_addr !== 10'd6) begin n_fail++; $display("FAIL branch_not_taken: got %0d expected 6", bus.imem_addr); end
        run_instr(h);
        rom[0] = 9'b1_1111_1111; rom[1023] = 9'b0_1110_0000;
        az_mode = 1;
        start_pulse();
        run_instr(h);
        n_checks++; if (bus.imem_addr !== 10'd1023) begin n_fail++; $display("FAIL branch_wrap: got %0d expected 1023", bus.imem_addr); end
        run_instr(h);
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL branch_wrap_halt: got %b expected 1", halted); end
        az_mode = 0;
    endtask

    task automatic test_reset_mid_mem();
        bit h;
        rom[0] = 9'b0_1011_0000; rom[1] = 9'b0_0011_0101;
        ao_mode = 2; noise = 1'b1;
        start_pulse();
        run_instr(h);
        noise = 1'b0; ao_mode = 0;
        bus.dmem_ready = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        n_checks++; if ({bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we} !== 4'b0) begin n_fail++; $display("FAIL busy_start_exec: got %b expected 0000", {bus.acc_we, bus.reg_we, bus.dmem_re, bus.dmem_we}); end
        @(negedge CLK);
        @(negedge CLK);
        n_checks++; if (bus.dmem_we !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL store_in_mem: got we=%b busy=%b expected 1/1", bus.dmem_we, busy); end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; start = 1'b0;
        n_checks++; if ({bus.dmem_we, bus.dmem_re, bus.acc_we, bus.reg_we, busy, halted, bus.overflow_q} !== 7'b0) begin n_fail++; $display("FAIL mid_mem_reset: got %b expected 0000000", {bus.dmem_we, bus.dmem_re, bus.acc_we, bus.reg_we, busy, halted, bus.overflow_q}); end
        n_checks++; if (instr_count !== 16'd0 || bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL mid_mem_reset_regs: got cnt=%0d pc=%0d expected 0/0", instr_count, bus.imem_addr); end
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_beats_start: got busy=%b expected 0", busy); end
    endtask

    task automatic test_random();
        bit got;
        noise = 1'b1; az_mode = 0; ao_mode = 0; mem_lat = 0;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 511));
            run_prog(60, got);
            if (!got) do_reset();
        end
        noise = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; start = 1'b0;
        bus.acc_zero = 1'b0; bus.alu_overflow = 1'b0; bus.dmem_ready = 1'b0;
        az_mode = 0; ao_mode = 0; mem_lat = 0; noise = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = 9'h0F0;
        test_reset();
        test_program();
        test_restart();
        test_overflow();
        test_load();
        test_branch();
        test_reset_mid_mem();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/accum_control_unit.md
# accum_control_unit

Multi-cycle fetch/decode/sequence controller for the 8-bit accumulator datapath. Fetches 9-bit instructions from a synchronous instruction ROM, decodes them into the ALU's `OP`/`type_bit` controls and the register-select field, sequences load/store through a handshaked data memory, and owns the program counter and the architectural overflow flag that feeds the ALU's `overflow_in`. Sits directly upstream of the ALU and drives the accumulator and register-file write enables.

## Interface
- `PC_W`, 10, program counter / instruction address width
- `CNT_W`, 16, retired-instruction counter width
- `CLK`  in  1  clock; all state updates on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `start`  in  1  begin execution at PC 0; honoured only in IDLE or HALTED
- `imem_addr`  out  PC_W  instruction ROM address (= PC)
- `imem_rdata`  in  9  ROM data, valid one cycle after address
- `OP`  out  4  ALU opcode = IR[7:4]
- `type_bit`  out  1  ALU type bit = IR[8]
- `reg_sel`  out  4  register index = IR[3:0]
- `acc_zero`  in  1  accumulator == 0
- `alu_overflow`  in  1  ALU `overflow_out`
- `overflow_q`  out  1  overflow flag, to ALU `overflow_in`
- `acc_we`  out  1  accumulator write enable
- `reg_we`  out  1  register-file write enable
- `dmem_re` / `dmem_we`  out  1 each  data memory read/write request
- `dmem_ready`  in  1  data memory completion
- `halted`  out  1  high in HALTED
- `busy`  out  1  high in FETCH/DECODE/EXEC/MEM
- `instr_count`  out  CNT_W  retired instructions, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALTED.
- IDLE --start--> FETCH (PC←0, overflow_q←0, instr_count←0). HALTED --start--> same. `start` ignored elsewhere.
- FETCH: `imem_addr`=PC; → DECODE.
- DECODE: IR←`imem_rdata` at end of cycle; → EXEC.
- EXEC, type_bit=0, by OP:
  - 0 take, 4 xor, 5 nand, 6 shl, 7 shr, 8 lookup, 9 lsn, 10 eql, 12 sub: `acc_we`=1 one cycle.
  - 11 add: `acc_we`=1; overflow_q←`alu_overflow`.
  - 1 put: `reg_we`=1.
  - 2 load, 3 store: → MEM (no enables in EXEC).
  - 13 of0: overflow_q←0. 15 tba: no-op.
  - 14 halt: → HALTED; PC not advanced; counted as retired.
- EXEC, type_bit=1 (branch): PC←`acc_zero` ? PC+1 : PC+sign_extend(IR[7:0]) to PC_W; no enables.
- MEM: load holds `dmem_re`=1, store holds `dmem_we`=1 from entry until the cycle `dmem_ready`=1 (inclusive). Load asserts `acc_we` in that ready cycle only. Then PC←PC+1, → FETCH.
- Non-memory, non-halt: PC←PC+1 (or branch target) at end of EXEC, → FETCH.
- overflow_q changes only on add, of0, start, RESET.
- PC arithmetic modulo 2^PC_W (PC max +1 → 0; negative offsets wrap).
- instr_count +1 per retired instruction; holds at all-ones.
- `OP`/`type_bit`/`reg_sel` combinational from IR at all times.

## Timing
- RESET (sync, any state incl. mid-MEM): state←IDLE; PC, IR, overflow_q, instr_count←0; all enables, `halted`, `busy` low from the next cycle. Outstanding memory request dropped.
- Non-memory instruction: 3 cycles (FETCH, DECODE, EXEC). Load/store: 3 + N, N≥1 = cycles in MEM until `dmem_ready`.
- `dmem_ready` sampled only in MEM; ignored elsewhere.
- Write enables are single-cycle pulses; never two in the same cycle.
- `start` same cycle as RESET: RESET wins.

## Test plan
- RESET then start; ROM = take r1 (0_0000_0001), xor r2 (0_0100_0010), halt (0_1110_0000) -> `acc_we` pulses in cycles 3 and 6; `halted`=1 from cycle 10; PC=2; instr_count=3.
- add with `alu_overflow`=1, then sub, then of0 -> overflow_q 1 after add, still 1 after sub, 0 after of0.
- load r3 with `dmem_ready` low 3 cycles in MEM -> `dmem_re` high exactly 4 cycles, `acc_we` only in the 4th; instruction spans 7 cycles.
- Branch at PC=5, IR=1_1111_1110 (−2): `acc_zero`=0 -> next fetch at 3; `acc_zero`=1 -> next fetch at 6. Branch at PC=0 with offset −1 -> PC=1023.
- RESET asserted mid-MEM during store -> `dmem_we` low next cycle, state IDLE, all outputs 0; `start` during busy execution ignored.
- start pulse in HALTED -> PC=0, overflow_q=0, instr_count=0, fetch resumes.
